mux8_rr_sched: RTL

Round-robin scheduler that shares one 8:1 multiplexer (mux8a1) among eight requesters. It drives the mux select code and a one-hot grant vector, and enforces a maximum tenure per grant. It inserts one dead cycle between owners so downstream logic never samples the mux output mid-switch. It sits directly in front of the mux select inputs.

---
 rtl/mux8_rr_sched.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mux8_rr_sched.sv
// -----------------------------------------------------------------------------
// mux8_rr_sched
//
// Round-robin scheduler that shares one 8:1 multiplexer among eight
// requesters. It drives the mux select code and a one-hot grant vector. Each
// grant has a bounded tenure, and one dead cycle separates successive owners,
// so logic downstream of the mux never samples a half-switched output.
//
// Ports:
//   clk            in   1  system clock, all state updates on rising edge
//   rst            in   1  synchronous active-high reset
//   req            in   8  req[i] asks for mux data input i
//   done           in   1  current owner finished (only looked at while valid=1)
//   sel            out  3  mux select code; index of the current/last owner
//   grant          out  8  one-hot grant, all zero when there is no owner
//   valid          out  1  mux output belongs to the grant owner this cycle
//   slice_expired  out  1  one-cycle pulse in the dead cycle that follows a
//                          release caused only by the tenure limit
//   dbg_state      out  2  current FSM state (IDLE=0, BUSY=1, SWITCH=2)
//
// Parameters:
//   SLICE_MAX  maximum consecutive valid cycles per grant; 0 = unlimited
//   CNT_W      tenure counter width; must be able to hold SLICE_MAX
//
// Handshake: a requester owns the mux output in exactly the cycles where its
// grant bit is set. valid is high in those same cycles. done is honoured only
// in a cycle where valid=1. A request has no acknowledge other than the grant,
// and a requester keeps req high for as long as it wants to keep the mux.
// -----------------------------------------------------------------------------
module mux8_rr_sched #(
    parameter int unsigned SLICE_MAX = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       valid,
    output logic       slice_expired,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_SLICE   = CNT_W'(SLICE_MAX);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_TOP = '1;
    localparam bit               C_LIMITED = (SLICE_MAX != 0);
    // In unlimited mode the counter only has to stop short of wrapping.
    localparam logic [CNT_W-1:0] C_CNT_CEIL = C_LIMITED ? C_SLICE : C_CNT_TOP;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [2:0]       r_sel;
    logic [7:0]       r_grant;
    logic             r_valid;
    logic             r_slice_exp;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_last;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic             w_arb_found;
    logic [2:0]       w_arb_idx;
    logic [2:0]       w_cand;
    logic             w_owner_req;
    logic             w_at_limit;
    logic             w_release;

    state_t           w_state_nxt;
    logic [2:0]       w_sel_nxt;
    logic [7:0]       w_grant_nxt;
    logic             w_valid_nxt;
    logic             w_slice_exp_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_last_nxt;

    // ------------------------------------------------------------------
    // Round-robin search: start one past the last owner and wrap. The
    // 3-bit add wraps mod 8 on its own. The last owner itself is the final
    // candidate, so a lone requester gets the mux again.
    // ------------------------------------------------------------------
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = r_last;
        w_cand      = r_last;
        for (int k = 1; k <= 8; k++) begin
            w_cand = r_last + 3'(k);
            if (!w_arb_found && req[w_cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Release conditions while BUSY
    // ------------------------------------------------------------------
    always_comb begin
        w_owner_req = req[r_sel];
        w_at_limit  = C_LIMITED && (r_cnt == C_SLICE);
        w_release   = done || !w_owner_req || w_at_limit;
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_grant_nxt     = r_grant;
        w_valid_nxt     = r_valid;
        w_slice_exp_nxt = 1'b0;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;

        unique case (r_state)
            ST_IDLE, ST_SWITCH: begin
                if (w_arb_found) begin
                    w_state_nxt = ST_BUSY;
                    w_sel_nxt   = w_arb_idx;
                    w_grant_nxt = 8'h01 << w_arb_idx;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = C_ONE;
                    w_last_nxt  = w_arb_idx;
                end else begin
                    // Nobody is asking. sel keeps pointing at the last
                    // owner so the mux select lines stay quiet.
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 8'h00;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end

            ST_BUSY: begin
                if (w_release) begin
                    w_state_nxt = ST_SWITCH;
                    w_grant_nxt = 8'h00;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    // Flag the release as an expiry only when the limit is
                    // the sole cause. A finish that arrives on the same cycle
                    // still counts as a normal release.
                    w_slice_exp_nxt = w_at_limit && !done && w_owner_req;
                end else if (r_cnt != C_CNT_CEIL) begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 8'h00;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= 3'd0;
            r_grant     <= 8'h00;
            r_valid     <= 1'b0;
            r_slice_exp <= 1'b0;
            r_cnt       <= '0;
            r_last      <= 3'd7;    // so that req[0] is searched first
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_grant     <= w_grant_nxt;
            r_valid     <= w_valid_nxt;
            r_slice_exp <= w_slice_exp_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
        end
    end

    assign sel           = r_sel;
    assign grant         = r_grant;
    assign valid         = r_valid;
    assign slice_expired = r_slice_exp;
    assign dbg_state     = r_state;

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(r_grant));

    a_valid_matches_grant : assert property (@(posedge clk) disable iff (rst)
        r_valid == (r_grant != 8'h00));

    a_expired_only_in_switch : assert property (@(posedge clk) disable iff (rst)
        r_slice_exp |-> (r_state == ST_SWITCH));

    a_sel_held_in_switch : assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_SWITCH) |-> $stable(r_sel));

endmodule
